// File: rtl/timer_pkg.sv
// Shared types and constants for the minutes:seconds countdown controller.
package timer_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_W = 7;
  localparam int SEC_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  // Saturate a minutes load value to the configured ceiling.
  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] value,
                                                 input logic [MIN_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  // Saturate a seconds load value to 59.
  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] value);
    return (value > SEC_MAX) ? SEC_MAX : value;
  endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Command/status bundle between board inputs and the countdown controller.
interface countdown_sequencer_if;
  import timer_pkg::*;

  logic             Load;
  logic [MIN_W-1:0] MinIn;
  logic [SEC_W-1:0] SecIn;
  logic             StartStop;
  logic             Clear;
  logic [MIN_W-1:0] Minutes;
  logic [SEC_W-1:0] Seconds;
  logic             Running;
  logic             Done;

  // Board side: issues commands, watches the display/alarm status.
  modport master (
    output Load, MinIn, SecIn, StartStop, Clear,
    input  Minutes, Seconds, Running, Done
  );

  // Controller side.
  modport slave (
    input  Load, MinIn, SecIn, StartStop, Clear,
    output Minutes, Seconds, Running, Done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Down-counting prescaler producing one Tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Restart,
  output logic Tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign Tick = Enable && (r_count == '0);

  // Count down while enabled; reload on wrap or on an explicit restart.
  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!Reset) begin
      r_count <= RELOAD;
    end else if (Restart) begin
      r_count <= RELOAD;
    end else if (Enable) begin
      r_count <= (r_count == '0) ? RELOAD : r_count - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Kitchen-timer controller: load/start/pause/clear FSM and min:sec counter,
// sequencing its own one-per-second prescaler.
module countdown_sequencer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 99
) (
  input  logic                 Clock,
  input  logic                 Reset,
  countdown_sequencer_if.slave bus
);

  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [MIN_W-1:0] r_min;
  logic [MIN_W-1:0] w_min_nxt;
  logic [SEC_W-1:0] r_sec;
  logic [SEC_W-1:0] w_sec_nxt;
  logic             w_restart;
  logic             w_tick;
  logic             w_zero;

  assign w_zero = (r_min == '0) && (r_sec == '0);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (r_state == RUN),
    .Restart (w_restart),
    .Tick    (w_tick)
  );

  // State and count registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= STOP;
      r_min   <= '0;
      r_sec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
    end
  end

  // Next state and next count: Clear > Load > StartStop > tick.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_restart   = 1'b0;

    if (bus.Clear) begin
      w_state_nxt = STOP;
      w_min_nxt   = '0;
      w_sec_nxt   = '0;
      w_restart   = 1'b1;
    end else begin
      unique case (r_state)
        STOP: begin
          if (bus.Load) begin
            w_min_nxt = clamp_min(bus.MinIn, MAX_MIN_V);
            w_sec_nxt = clamp_sec(bus.SecIn);
          end else if (bus.StartStop && !w_zero) begin
            // Fresh full second on every start, so a pause drops the fraction.
            w_state_nxt = RUN;
            w_restart   = 1'b1;
          end
        end
        RUN: begin
          if (bus.StartStop) begin
            w_state_nxt = STOP;
          end else if (w_tick) begin
            if (r_sec != '0) begin
              w_sec_nxt = r_sec - 1'b1;
            end else begin
              w_min_nxt = r_min - 1'b1;
              w_sec_nxt = SEC_MAX;
            end
            if ((r_min == '0) && (r_sec == 6'd1)) begin
              w_state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (bus.Load) begin
            w_state_nxt = STOP;
            w_min_nxt   = clamp_min(bus.MinIn, MAX_MIN_V);
            w_sec_nxt   = clamp_sec(bus.SecIn);
          end
        end
        default: begin
          w_state_nxt = STOP;
        end
      endcase
    end
  end

  assign bus.Minutes = r_min;
  assign bus.Seconds = r_sec;
  assign bus.Running = (r_state == RUN);
  assign bus.Done    = (r_state == DONE);

endmodule
